// File: rtl/hc_sr04_pkg.sv
// Shared definitions for the HC-SR04 sensor emulator.
// Holds the FSM state encoding and the sensor constants that the
// measurement controller also uses, so both sides agree on one value.
package hc_sr04_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRIG    = 3'd1,
        S_BURST   = 3'd2,
        S_ECHO    = 3'd3,
        S_HOLDOFF = 3'd4
    } state_e;

    localparam int US_PER_CM_DEFAULT       = 58;
    localparam int ECHO_TIMEOUT_US_DEFAULT = 38000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hc_sr04_trig_sync.sv
// Two-flop synchronizer for the asynchronous trigger input plus an edge
// detector on the synchronized level.
// Ports: clk_i, rst_ni, trigger_i (async), trig_s_o (synchronized level,
// 2 clk latency), trig_rise_o / trig_fall_o (one-clk edge strobes).
module hc_sr04_trig_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic trigger_i,
    output logic trig_s_o,
    output logic trig_rise_o,
    output logic trig_fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= trigger_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign trig_s_o    = sync_q;
    assign trig_rise_o = sync_q & ~prev_q;
    assign trig_fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/prm_register.sv
// Generic register with synchronous active-low reset.
// Ports: clk_i, rst_ni, d_i (next value), q_o (registered value).
module prm_register #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_o <= RESET_VAL;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/prm_register_we.sv
// Generic register with write enable and synchronous active-low reset.
// Ports: clk_i, rst_ni, we_i (load d_i when high), d_i, q_o.
module prm_register_we #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_o <= RESET_VAL;
        end else if (we_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/hc_sr04_emu.sv
// Responder-side HC-SR04 emulator. Validates the trigger width, waits the
// burst delay, drives an echo whose width encodes distance_cm_i, then
// holds off before accepting another trigger. Time is counted in
// strobe_us_i pulses.
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   strobe_us_i         one-clk pulse per microsecond
//   trigger_i           trigger from the controller (asynchronous)
//   distance_cm_i       emulated distance, latched at trigger fall
//   object_present_i    0 = no target, echo uses the timeout width
//   echo_o              registered echo pulse
//   busy_o              high whenever a measurement is in progress
//   trig_err_o          one-clk pulse when the trigger was too short
module hc_sr04_emu
    import hc_sr04_pkg::*;
#(
    parameter int TRIG_MIN_US     = 10,
    parameter int BURST_DELAY_US  = 200,
    parameter int US_PER_CM       = US_PER_CM_DEFAULT,
    parameter int ECHO_TIMEOUT_US = ECHO_TIMEOUT_US_DEFAULT,
    parameter int HOLDOFF_US      = 10000,
    parameter int DIST_WIDTH      = 9,
    parameter int CNT_WIDTH       = $clog2(max_int(ECHO_TIMEOUT_US, HOLDOFF_US) + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  strobe_us_i,
    input  logic                  trigger_i,
    input  logic [DIST_WIDTH-1:0] distance_cm_i,
    input  logic                  object_present_i,
    output logic                  echo_o,
    output logic                  busy_o,
    output logic                  trig_err_o
);

    localparam int RAW_W = DIST_WIDTH + 7;

    localparam logic [CNT_WIDTH-1:0] TRIG_MIN_C = CNT_WIDTH'(TRIG_MIN_US);
    localparam logic [CNT_WIDTH-1:0] BURST_C    = CNT_WIDTH'(BURST_DELAY_US);
    localparam logic [CNT_WIDTH-1:0] HOLDOFF_C  = CNT_WIDTH'(HOLDOFF_US);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C  = CNT_WIDTH'(ECHO_TIMEOUT_US);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    // Trigger synchronization. Only the edges steer the FSM; the level is
    // left unused here.
    logic unused_trig_s;
    logic trig_rise;
    logic trig_fall;

    hc_sr04_trig_sync u_trig_sync (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .trigger_i   (trigger_i),
        .trig_s_o    (unused_trig_s),
        .trig_rise_o (trig_rise),
        .trig_fall_o (trig_fall)
    );

    // State register
    state_e         state_q;
    state_e         state_d;
    logic [2:0]     state_raw;

    prm_register #(.WIDTH(3), .RESET_VAL(3'd0)) u_state_reg (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (state_d),
        .q_o    (state_raw)
    );
    assign state_q = state_e'(state_raw);

    // Microsecond counter: restarts from zero on every state change so each
    // state measures its own dwell time, saturates so a stuck trigger
    // cannot wrap it back below the minimum.
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (strobe_us_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    prm_register #(.WIDTH(CNT_WIDTH)) u_cnt_reg (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (cnt_d),
        .q_o    (cnt_q)
    );

    // Echo width, latched once at the trigger fall so later input changes
    // do not disturb the measurement in flight.
    logic [RAW_W-1:0]     raw;
    logic [CNT_WIDTH-1:0] width_d;
    logic [CNT_WIDTH-1:0] width_q;
    logic [CNT_WIDTH-1:0] width_m1;
    logic                 width_we;

    assign raw = RAW_W'(distance_cm_i) * RAW_W'(US_PER_CM);

    always_comb begin
        width_d = CNT_WIDTH'(raw);
        if (!object_present_i || (32'(raw) > ECHO_TIMEOUT_US)) begin
            width_d = TIMEOUT_C;
        end else if (raw == '0) begin
            // A zero-width echo would never be seen; report the minimum.
            width_d = CNT_WIDTH'(1);
        end
    end

    assign width_we = (state_q == S_TRIG) && (state_d == S_BURST);
    assign width_m1 = width_q - CNT_WIDTH'(1);

    prm_register_we #(.WIDTH(CNT_WIDTH)) u_width_reg (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .we_i   (width_we),
        .d_i    (width_d),
        .q_o    (width_q)
    );

    // Next-state logic
    logic trig_err_d;

    always_comb begin
        state_d    = state_q;
        trig_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Edge-triggered: a trigger already high when we return
                // here is ignored until it goes low and rises again.
                if (trig_rise) begin
                    state_d = S_TRIG;
                end
            end
            S_TRIG: begin
                if (trig_fall) begin
                    if (cnt_q >= TRIG_MIN_C) begin
                        state_d = S_BURST;
                    end else begin
                        state_d    = S_IDLE;
                        trig_err_d = 1'b1;
                    end
                end
            end
            S_BURST: begin
                if (strobe_us_i && (cnt_q == BURST_C)) begin
                    state_d = S_ECHO;
                end
            end
            S_ECHO: begin
                // Leaving on the width-th strobe keeps echo high for exactly
                // width strobe periods.
                if (strobe_us_i && (cnt_q == width_m1)) begin
                    state_d = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (strobe_us_i && (cnt_q == HOLDOFF_C)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs registered from next-state so echo changes on the same edge
    // as the state that owns it.
    logic echo_q;
    logic trig_err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            echo_q     <= 1'b0;
            trig_err_q <= 1'b0;
        end else begin
            echo_q     <= (state_d == S_ECHO);
            trig_err_q <= trig_err_d;
        end
    end

    assign echo_o     = echo_q;
    assign trig_err_o = trig_err_q;
    assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_hc_sr04_emu.sv
// Bench for hc_sr04_emu with shortened timing parameters.
// Driver tasks issue triggers and push the expected response into a queue;
// a negedge monitor measures echo, burst and holdoff in strobe periods and
// pops/compares against the reference computed from distance arithmetic.
module tb_hc_sr04_emu;

    localparam int TRIG_MIN   = 10;
    localparam int BURST      = 50;
    localparam int UPC        = 3;
    localparam int TIMEOUT    = 400;
    localparam int HOLDOFF    = 200;
    localparam int DW         = 9;

    typedef struct {
        bit is_err;
        int width;
        int start;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          strobe;
    logic          trigger;
    logic [DW-1:0] distance;
    logic          obj;
    logic          echo;
    logic          busy;
    logic          trig_err;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    hc_sr04_emu #(
        .TRIG_MIN_US     (TRIG_MIN),
        .BURST_DELAY_US  (BURST),
        .US_PER_CM       (UPC),
        .ECHO_TIMEOUT_US (TIMEOUT),
        .HOLDOFF_US      (HOLDOFF),
        .DIST_WIDTH      (DW)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .strobe_us_i      (strobe),
        .trigger_i        (trigger),
        .distance_cm_i    (distance),
        .object_present_i (obj),
        .echo_o           (echo),
        .busy_o           (busy),
        .trig_err_o       (trig_err)
    );

    // ---------------- clock / reset / strobe ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Strobe: one clk high, period randomly 3 or 4 clocks.
    initial begin
        strobe = 1'b0;
        forever begin
            @(posedge clk);
            #1 strobe = 1'b1;
            @(posedge clk);
            #1 strobe = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
        end
    end

    // ---------------- reference model ----------------
    function automatic int model_width(input int d, input bit op);
        int raw;
        raw = d * UPC;
        if (!op || raw > TIMEOUT) return TIMEOUT;
        if (raw == 0) return 1;
        return raw;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_strobe_cycle();
        int k;
        k = 0;
        do begin
            next_cycle();
            k++;
        end while (!strobe && k < 20);
    endtask

    // Hold trigger high for n strobe periods, starting on a strobe cycle.
    task automatic pulse(input int n, output int drop_cyc);
        int k;
        wait_strobe_cycle();
        trigger = 1'b1;
        k = 0;
        while (k < n) begin
            next_cycle();
            if (strobe) k++;
        end
        trigger  = 1'b0;
        drop_cyc = cyc;
    endtask

    task automatic run_meas(input int n, input int d, input bit op);
        int   c;
        exp_t e;
        distance = DW'(d);
        obj      = op;
        pulse(n, c);
        e.is_err = (n < TRIG_MIN);
        e.width  = model_width(d, op);
        // trig_s falls 2 clk later, the FSM reacts one clk after that.
        e.start  = c + 3;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 5000) begin
            next_cycle();
            k++;
        end
        if (k >= 5000) check("idle_timeout", int'(busy), 0);
        repeat (4) next_cycle();
    endtask

    task automatic wait_echo(input logic level);
        int k;
        k = 0;
        while (echo != level && k < 3000) begin
            next_cycle();
            k++;
        end
        if (k >= 3000) check("echo_wait_timeout", int'(echo), int'(level));
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit   in_echo  = 1'b0;
    bit   in_hold  = 1'b0;
    bit   echo_ok  = 1'b0;
    bit   err_prev = 1'b0;
    int   echo_cnt = 0;
    int   hold_cnt = 0;
    int   burst_cnt = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_echo   = 1'b0;
            in_hold   = 1'b0;
            err_prev  = 1'b0;
            echo_cnt  = 0;
            hold_cnt  = 0;
            burst_cnt = 0;
        end else begin
            if (trig_err) begin
                check("trig_err_single_clk", int'(err_prev), 0);
                check("trig_err_expected", int'(exp_q.size() > 0 && exp_q[0].is_err), 1);
                if (exp_q.size() > 0 && exp_q[0].is_err) begin
                    mon_e = exp_q.pop_front();
                    check("trig_err_cycle", cyc, mon_e.start);
                end
            end
            err_prev = trig_err;

            if (echo) begin
                if (!in_echo) begin
                    in_echo  = 1'b1;
                    echo_cnt = 0;
                    echo_ok  = (exp_q.size() > 0 && !exp_q[0].is_err);
                    check("echo_expected", int'(echo_ok), 1);
                    if (echo_ok) check("burst_strobes", burst_cnt, BURST + 1);
                    burst_cnt = 0;
                end
                if (strobe) echo_cnt++;
            end else begin
                if (in_echo) begin
                    in_echo  = 1'b0;
                    in_hold  = 1'b1;
                    hold_cnt = 0;
                    if (echo_ok) begin
                        mon_e = exp_q.pop_front();
                        check("echo_width_us", echo_cnt, mon_e.width);
                    end
                end
                if (in_hold) begin
                    if (busy) begin
                        if (strobe) hold_cnt++;
                    end else begin
                        check("holdoff_strobes", hold_cnt, HOLDOFF + 1);
                        in_hold = 1'b0;
                    end
                end else if (exp_q.size() > 0 && !exp_q[0].is_err &&
                             cyc >= exp_q[0].start && strobe) begin
                    burst_cnt++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int dummy;
        rst_n    = 1'b0;
        trigger  = 1'b0;
        distance = '0;
        obj      = 1'b1;
        repeat (5) next_cycle();
        rst_n = 1'b1;
        #1;
        check("reset_echo", int'(echo), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_trig_err", int'(trig_err), 0);
        repeat (4) next_cycle();

        // Basic measurement and short-trigger error.
        run_meas(12, 20, 1'b1);   wait_idle();
        run_meas(5, 20, 1'b1);    wait_idle();
        // Minimum-width boundary on both sides.
        run_meas(9, 20, 1'b1);    wait_idle();
        run_meas(10, 20, 1'b1);   wait_idle();
        // Width clamps.
        run_meas(11, 20, 1'b0);   wait_idle();
        run_meas(11, 500, 1'b1);  wait_idle();
        run_meas(11, 0, 1'b1);    wait_idle();
        run_meas(11, 133, 1'b1);  wait_idle();
        run_meas(11, 134, 1'b1);  wait_idle();

        // Triggers during echo and holdoff are ignored.
        run_meas(12, 20, 1'b1);
        wait_echo(1'b1);
        repeat (10) next_cycle();
        pulse(4, dummy);
        wait_echo(1'b0);
        repeat (10) next_cycle();
        pulse(15, dummy);
        wait_idle();
        run_meas(12, 30, 1'b1);   wait_idle();

        // Distance change after the latch has no effect on this echo.
        run_meas(12, 20, 1'b1);
        repeat (10) next_cycle();
        distance = DW'(40);
        wait_idle();
        run_meas(12, 40, 1'b1);   wait_idle();

        // Long trigger, still a valid measurement.
        run_meas(100, 7, 1'b1);   wait_idle();

        // Randomized measurements.
        for (int i = 0; i < 5; i++) begin
            run_meas($urandom_range(2, 20), $urandom_range(0, 160),
                     $urandom_range(0, 3) != 0);
            wait_idle();
        end

        // Reset in the middle of an echo.
        run_meas(11, 60, 1'b1);
        wait_echo(1'b1);
        repeat (30) next_cycle();
        rst_n = 1'b0;
        exp_q.delete();
        next_cycle();
        rst_n = 1'b1;
        #1;
        check("midecho_reset_echo", int'(echo), 0);
        check("midecho_reset_busy", int'(busy), 0);
        repeat (4) next_cycle();
        run_meas(10, 20, 1'b1);   wait_idle();

        repeat (10) next_cycle();
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
